// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream handshake plus instruction-SRAM write port seen
//                by the boot-time program loader.
//                'slave' is the loader's view: it consumes the byte stream
//                and drives the SRAM write port.
//                'master' is the upstream/system view.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if;
    // Stream side
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;

    // Instruction SRAM write port
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_din
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_din
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time program loader. Parses a framed byte stream
//                (sync 0xA5, length N, 2N data bytes LSB-first per word,
//                8-bit additive checksum), writes each 16-bit word into
//                instruction SRAM and holds the CPU in reset until a
//                complete, checksum-valid program has been written.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int MEM_SIZE = 32
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         done,
    output logic         err,
    output logic [7:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [7:0] c_sync    = 8'hA5;
    // One extra bit so an 8-bit length can be compared against any depth.
    localparam logic [8:0] c_max_len = 9'(MEM_SIZE);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_len;
    logic [7:0]  r_low;
    logic [7:0]  r_csum;
    logic [7:0]  r_word_count;
    logic        r_mem_we;
    logic [7:0]  r_mem_addr;
    logic [15:0] r_mem_din;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_last;
    logic        w_len_bad;
    logic        w_clr_count;
    logic        w_latch_len;
    logic        w_latch_low;
    logic        w_write;
    logic        w_csum_clr;
    logic        w_csum_add;

    // The HI byte currently on the bus completes the final word of the frame.
    assign w_last    = ((r_word_count + 8'd1) == r_len);
    assign w_len_bad = (bus.in_data == 8'd0) || ({1'b0, bus.in_data} > c_max_len);

    // State register; an asynchronous reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath control strobes for the accepted byte.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = (r_state != S_DONE);
        w_accept    = bus.in_valid && (r_state != S_DONE);
        w_clr_count = 1'b0;
        w_latch_len = 1'b0;
        w_latch_low = 1'b0;
        w_write     = 1'b0;
        w_csum_clr  = 1'b0;
        w_csum_add  = 1'b0;

        if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_data == c_sync) begin
                        w_clr_count = 1'b1;
                        w_state_nxt = S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_len_bad) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_latch_len = 1'b1;
                        w_csum_clr  = 1'b1;
                        w_state_nxt = S_LO;
                    end
                end
                S_LO: begin
                    w_latch_low = 1'b1;
                    w_csum_add  = 1'b1;
                    w_state_nxt = S_HI;
                end
                S_HI: begin
                    w_write     = 1'b1;
                    w_csum_add  = 1'b1;
                    w_state_nxt = w_last ? S_CSUM : S_LO;
                end
                S_CSUM: begin
                    w_state_nxt = (bus.in_data == r_csum) ? S_DONE : S_ERROR;
                end
                S_ERROR: begin
                    // Only a fresh sync byte restarts; everything else is dropped.
                    if (bus.in_data == c_sync) begin
                        w_clr_count = 1'b1;
                        w_state_nxt = S_LEN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Frame datapath: length/low-byte latches, checksum, word counter and the
    // registered SRAM write port. Address/data hold after the strobe drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len        <= 8'd0;
            r_low        <= 8'd0;
            r_csum       <= 8'd0;
            r_word_count <= 8'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 8'd0;
            r_mem_din    <= 16'd0;
        end else begin
            r_mem_we <= w_write;

            if (w_latch_len) begin
                r_len <= bus.in_data;
            end

            if (w_latch_low) begin
                r_low <= bus.in_data;
            end

            // Checksum wraps naturally at 8 bits.
            if (w_csum_clr) begin
                r_csum <= 8'd0;
            end else if (w_csum_add) begin
                r_csum <= r_csum + bus.in_data;
            end

            if (w_clr_count) begin
                r_word_count <= 8'd0;
            end else if (w_write) begin
                r_word_count <= r_word_count + 8'd1;
            end

            if (w_write) begin
                r_mem_addr <= r_word_count;
                r_mem_din  <= {bus.in_data, r_low};
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;

    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERROR);
    // The CPU is released only once a verified program is in place.
    assign cpu_rst    = (r_state != S_DONE);
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Frames are built by the
//                bench, so the expected SRAM writes and final status follow
//                directly from the frame contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int MEM_SIZE = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_rst;
    logic       done;
    logic       err;
    logic [7:0] word_count;

    imem_loader_if bus ();

    imem_loader #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  data_q[$];
    logic [7:0]  obs_addr[$];
    logic [15:0] obs_din[$];
    logic        prev_we = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observe SRAM writes mid-cycle; each strobe must be a single cycle and
    // word_count must already reflect the word being written.
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (bus.mem_we) begin
                chk("we_single_cycle", 32'(prev_we), 32'd0);
                chk("wc_with_we", 32'(word_count), 32'(bus.mem_addr) + 32'd1);
                obs_addr.push_back(bus.mem_addr);
                obs_din.push_back(bus.mem_din);
            end
            prev_we = bus.mem_we;
        end
    end

    // Present one byte after 0..max_gap idle cycles; always returns at edge+1.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        chk("in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_we"},   32'(bus.mem_we),   32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_din"},  32'(bus.mem_din),  32'd0);
        chk({tag, "_cpu_rst"},  32'(cpu_rst),      32'd1);
        chk({tag, "_done"},     32'(done),         32'd0);
        chk({tag, "_err"},      32'(err),          32'd0);
        chk({tag, "_wc"},       32'(word_count),   32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    function automatic logic [7:0] rand_non_sync();
        logic [7:0] g;
        g = 8'($urandom_range(255, 0));
        if (g == 8'hA5) g = 8'h5A;
        return g;
    endfunction

    // csum_sel: -1 correct checksum, -2 corrupted checksum, else explicit byte.
    task automatic run_frame(input int n, input int csum_sel, input int max_gap, input int n_garbage);
        logic [7:0] sum;
        logic [7:0] cs;
        bit         ok;
        int         nw;
        sum = 8'd0;
        obs_addr.delete();
        obs_din.delete();

        for (int i = 0; i < n_garbage; i++) send_byte(rand_non_sync(), max_gap);
        chk("garbage_no_write", 32'(obs_addr.size()), 32'd0);

        send_byte(8'hA5, max_gap);
        chk("sync_err", 32'(err), 32'd0);
        chk("sync_wc", 32'(word_count), 32'd0);
        chk("sync_cpu_rst", 32'(cpu_rst), 32'd1);

        send_byte(8'(n), max_gap);
        if (n == 0 || n > MEM_SIZE) begin
            chk("len_err", 32'(err), 32'd1);
            chk("len_done", 32'(done), 32'd0);
            chk("len_cpu_rst", 32'(cpu_rst), 32'd1);
            for (int i = 0; i < 3; i++) send_byte(rand_non_sync(), max_gap);
            chk("len_no_write", 32'(obs_addr.size()), 32'd0);
            chk("len_err_hold", 32'(err), 32'd1);
            chk("len_wc", 32'(word_count), 32'd0);
            return;
        end

        for (int i = 0; i < 2 * n; i++) begin
            sum = sum + data_q[i];
            send_byte(data_q[i], max_gap);
        end
        if (csum_sel == -1)      cs = sum;
        else if (csum_sel == -2) cs = sum + 8'($urandom_range(255, 1));
        else                     cs = 8'(csum_sel);
        ok = (cs == sum);
        send_byte(cs, max_gap);

        chk("done", 32'(done), 32'(ok));
        chk("err", 32'(err), 32'(!ok));
        chk("cpu_rst", 32'(cpu_rst), 32'(!ok));
        chk("word_count", 32'(word_count), 32'(n));
        chk("mem_we_low", 32'(bus.mem_we), 32'd0);
        chk("n_writes", 32'(obs_addr.size()), 32'(n));
        nw = (obs_addr.size() < n) ? obs_addr.size() : n;
        for (int i = 0; i < nw; i++) begin
            chk("waddr", 32'(obs_addr[i]), 32'(i));
            chk("wdata", 32'(obs_din[i]), 32'({data_q[2*i+1], data_q[2*i]}));
        end
        chk("addr_hold", 32'(bus.mem_addr), 32'(n - 1));
        chk("din_hold", 32'(bus.mem_din), 32'({data_q[2*n-1], data_q[2*n-2]}));

        if (ok) begin
            // Bytes offered in the loaded state must be refused.
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA5;
            for (int i = 0; i < 3; i++) begin
                chk("done_in_ready", 32'(bus.in_ready), 32'd0);
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b0;
            chk("done_hold", 32'(done), 32'd1);
            chk("done_no_write", 32'(obs_addr.size()), 32'(n));
            do_reset();
        end
    endtask

    task automatic load_nominal();
        data_q = '{8'h0A, 8'h05, 8'h01, 8'h02, 8'h07, 8'h00};
    endtask

    task automatic load_random(input int n);
        data_q.delete();
        for (int i = 0; i < 2 * n; i++) data_q.push_back(8'($urandom_range(255, 0)));
    endtask

    // Main stimulus sequence.
    initial begin
        int n;
        int r;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Nominal frame.
        load_nominal();
        run_frame(3, 8'h19, 0, 0);

        // Bad checksum, then recovery with the nominal frame.
        run_frame(3, 8'h18, 0, 0);
        run_frame(3, 8'h19, 0, 0);

        // Illegal lengths.
        run_frame(0, -1, 0, 0);
        run_frame(MEM_SIZE + 1, -1, 0, 0);

        // Leading garbage with flow-control gaps.
        do_reset();
        obs_addr.delete();
        obs_din.delete();
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        send_byte(8'h5A, 3);
        chk("lead_garbage_no_write", 32'(obs_addr.size()), 32'd0);
        chk("lead_garbage_wc", 32'(word_count), 32'd0);
        run_frame(3, 8'h19, 3, 0);

        // Mid-frame reset.
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h0A, 0);
        send_byte(8'h05, 0);
        send_byte(8'h01, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(3, 8'h19, 0, 0);

        // Maximum-length frame, data 0x00..0x3F.
        data_q.delete();
        for (int i = 0; i < 2 * MEM_SIZE; i++) data_q.push_back(8'(i));
        run_frame(MEM_SIZE, 8'hE0, 1, 0);

        // Randomized frames.
        for (int k = 0; k < 25; k++) begin
            r = int'($urandom_range(9, 0));
            if (r == 0)      n = 0;
            else if (r == 1) n = int'($urandom_range(255, MEM_SIZE + 1));
            else             n = int'($urandom_range(MEM_SIZE, 1));
            load_random(n);
            run_frame(n, ($urandom_range(3, 0) == 0) ? -2 : -1,
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
